mem_arbiter_ctrl: RTL

- Single-port memory controller. Shares the 8-bit synchronous RAM bus between instruction fetch (IF) and the load/store path fed by the execute stage's mem_addr/func3/wdata outputs.
- Serialises every 1/2/4-byte access into byte beats, assembles and extends load data, and returns a one-cycle done pulse to the requester.
- Sits between the IF/MEM pipeline stages and the top-level RAM pins.

---
 rtl/mem_arbiter_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter_ctrl.sv
// Single-port byte-wide RAM controller shared by instruction fetch and load/store.
// Each access is serialised into 1/2/4 little-endian byte beats; loads are assembled and extended.
module mem_arbiter_ctrl #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic [XLEN-1:0]   if_inst_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [2:0]        mem_func3_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [XLEN-1:0]   mem_wdata_i,
  output logic              mem_done_o,
  output logic [XLEN-1:0]   mem_rdata_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t            state;
  logic              last_mem, own_mem;
  logic [ADDR_W-1:0] base, ram_a_r, gbase;
  logic [3:0][7:0]   wdata_q, rbuf, rbuf_nx;
  logic [2:0]        f3_q, cnt, edge_n, nbeats;
  logic [7:0]        ram_dout_r;
  logic              ram_wr_r, if_done_r, mem_done_r;
  logic [XLEN-1:0]   if_inst_r, mem_rdata_r;
  logic              req_if, req_mem, pick_mem;

  function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [3:0][7:0] b);
    case (f3)
      3'b000:  return {{(XLEN-8){b[0][7]}}, b[0]};
      3'b001:  return {{(XLEN-16){b[1][7]}}, b[1], b[0]};
      3'b100:  return XLEN'(b[0]);
      3'b101:  return XLEN'({b[1], b[0]});
      default: return XLEN'(b);
    endcase
  endfunction

  always_comb begin
    // a requester still showing its done pulse is not regranted on its stale level request
    req_if   = if_req_i  & ~if_done_r;
    req_mem  = mem_req_i & ~mem_done_r;
    pick_mem = req_mem & (~req_if | ~last_mem);
    gbase    = pick_mem ? mem_addr_i : if_addr_i;
    edge_n   = cnt + 3'd1;
    case (f3_q[1:0])
      2'b00:   nbeats = 3'd1;
      2'b01:   nbeats = 3'd2;
      default: nbeats = 3'd4;
    endcase
    // byte k arrives two edges after its address, i.e. when cnt == k+1
    rbuf_nx = rbuf;
    if (cnt != 3'd0) rbuf_nx[cnt[1:0] - 2'd1] = ram_din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_mem    <= 1'b0;
      own_mem     <= 1'b0;
      base        <= '0;
      ram_a_r     <= '0;
      wdata_q     <= '0;
      rbuf        <= '0;
      f3_q        <= '0;
      cnt         <= '0;
      ram_dout_r  <= '0;
      ram_wr_r    <= 1'b0;
      if_done_r   <= 1'b0;
      mem_done_r  <= 1'b0;
      if_inst_r   <= '0;
      mem_rdata_r <= '0;
    end else if (rdy) begin
      if_done_r  <= 1'b0;
      mem_done_r <= 1'b0;
      case (state)
        IDLE: if (req_if || req_mem) begin
          own_mem  <= pick_mem;
          last_mem <= pick_mem;
          base     <= gbase;
          ram_a_r  <= gbase;
          f3_q     <= pick_mem ? mem_func3_i : 3'b010;
          wdata_q  <= mem_wdata_i[31:0];
          rbuf     <= '0;
          cnt      <= '0;
          if (pick_mem && mem_we_i) begin
            ram_dout_r <= mem_wdata_i[7:0];
            ram_wr_r   <= 1'b1;
            state      <= WRITE;
          end else begin
            state <= READ;
          end
        end
        READ: begin
          cnt  <= edge_n;
          rbuf <= rbuf_nx;
          if (edge_n < nbeats) ram_a_r <= base + ADDR_W'(edge_n);
          if (edge_n == nbeats + 3'd1) begin
            state   <= IDLE;
            ram_a_r <= '0;
            if (own_mem) begin
              mem_done_r  <= 1'b1;
              mem_rdata_r <= extend(f3_q, rbuf_nx);
            end else begin
              if_done_r <= 1'b1;
              if_inst_r <= extend(f3_q, rbuf_nx);
            end
          end
        end
        WRITE: begin
          cnt <= edge_n;
          if (edge_n < nbeats) begin
            ram_a_r    <= base + ADDR_W'(edge_n);
            ram_dout_r <= wdata_q[edge_n[1:0]];
          end else begin
            ram_wr_r   <= 1'b0;
            ram_a_r    <= '0;
            ram_dout_r <= '0;
            mem_done_r <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // strobes are masked while paused so a held register never repeats a write or a done
  assign ram_wr_o    = ram_wr_r & rdy;
  assign if_done_o   = if_done_r & rdy;
  assign mem_done_o  = mem_done_r & rdy;
  assign ram_a_o     = ram_a_r;
  assign ram_dout_o  = ram_dout_r;
  assign if_inst_o   = if_inst_r;
  assign mem_rdata_o = mem_rdata_r;
endmodule
